// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one system-bus master between debug requesters.
// Optional response timeout with Drain recovery: define DM_SBA_ARB_TIMEOUT_EN.
module dm_sba_arbiter #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   dmactive_i,
  input  logic [NumReq-1:0]                      req_i,
  input  logic [NumReq-1:0][BusWidth-1:0]        add_i,
  input  logic [NumReq-1:0]                      we_i,
  input  logic [NumReq-1:0][BusWidth-1:0]        wdata_i,
  input  logic [NumReq-1:0][BusWidth/8-1:0]      be_i,
  output logic [NumReq-1:0]                      gnt_o,
  output logic [NumReq-1:0]                      r_valid_o,
  output logic [NumReq-1:0]                      r_err_o,
  output logic [BusWidth-1:0]                    r_rdata_o,
  output logic                                   master_req_o,
  output logic [BusWidth-1:0]                    master_add_o,
  output logic                                   master_we_o,
  output logic [BusWidth-1:0]                    master_wdata_o,
  output logic [BusWidth/8-1:0]                  master_be_o,
  input  logic                                   master_gnt_i,
  input  logic                                   master_r_valid_i,
  input  logic [BusWidth-1:0]                    master_r_rdata_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] Idle  = 2'd0;
  localparam logic [1:0] Req   = 2'd1;
  localparam logic [1:0] Wait  = 2'd2;
`ifdef DM_SBA_ARB_TIMEOUT_EN
  localparam logic [1:0] Drain = 2'd3;
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
`endif

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [IdxW-1:0] win_nxt;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] sel;
  logic            any_req;

  // Cyclic scan upward from rr_q; the wrap is done without overflow bits.
  always_comb begin
    logic [IdxW-1:0] idx;
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (rr_q >= IdxW'(NumReq - i)) begin
        idx = rr_q - IdxW'(NumReq - i);
      end else begin
        idx = rr_q + IdxW'(i);
      end
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  assign win_nxt = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + 1'b1;

  // Idle presents requester 0 so the bus side never sees X-ish churn.
  assign sel            = (state_q == Idle) ? '0 : win_q;
  assign master_add_o   = add_i[sel];
  assign master_we_o    = we_i[sel];
  assign master_wdata_o = wdata_i[sel];
  assign master_be_o    = be_i[sel];

`ifdef DM_SBA_ARB_TIMEOUT_EN
  logic [CntW-1:0] cnt_q;
  logic            tmo;

  assign tmo = (state_q == Wait) && !master_r_valid_i &&
               (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == Wait) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign r_rdata_o = tmo ? '0 : master_r_rdata_i;
`else
  assign r_rdata_o = master_r_rdata_i;
  assign r_err_o   = '0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    win_d        = win_q;
    gnt_o        = '0;
    r_valid_o    = '0;
    master_req_o = 1'b0;
`ifdef DM_SBA_ARB_TIMEOUT_EN
    r_err_o      = '0;
`endif
    unique case (state_q)
      Idle: begin
        if (dmactive_i && any_req) begin
          win_d   = pick;
          state_d = Req;
        end
      end
      Req: begin
        master_req_o = req_i[win_q] & dmactive_i;
        gnt_o[win_q] = master_req_o & master_gnt_i;
        if (!master_req_o) begin
          state_d = Idle;
        end else if (master_gnt_i) begin
          state_d = Wait;
        end
      end
      Wait: begin
        r_valid_o[win_q] = master_r_valid_i & dmactive_i;
        if (master_r_valid_i) begin
          state_d = Idle;
          rr_d    = win_nxt;
        end
`ifdef DM_SBA_ARB_TIMEOUT_EN
        else if (tmo) begin
          r_valid_o[win_q] = dmactive_i;
          r_err_o[win_q]   = dmactive_i;
          state_d          = Drain;
        end
`endif
      end
`ifdef DM_SBA_ARB_TIMEOUT_EN
      Drain: begin
        if (master_r_valid_i) begin
          state_d = Idle;
          rr_d    = win_nxt;
        end
      end
`endif
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rr_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// Directed bench for dm_sba_arbiter: arbitration, muxing, abort, soft clear,
// async reset and (with DM_SBA_ARB_TIMEOUT_EN) the timeout/drain path.
module tb_dm_sba_arbiter;

  localparam int BW = 32;
  localparam int NR = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        dmactive_i;
  logic [NR-1:0]               req_i;
  logic [NR-1:0][BW-1:0]       add_i;
  logic [NR-1:0]               we_i;
  logic [NR-1:0][BW-1:0]       wdata_i;
  logic [NR-1:0][BW/8-1:0]     be_i;
  logic [NR-1:0]               gnt_o;
  logic [NR-1:0]               r_valid_o;
  logic [NR-1:0]               r_err_o;
  logic [BW-1:0]               r_rdata_o;
  logic                        master_req_o;
  logic [BW-1:0]               master_add_o;
  logic                        master_we_o;
  logic [BW-1:0]               master_wdata_o;
  logic [BW/8-1:0]             master_be_o;
  logic                        master_gnt_i;
  logic                        master_r_valid_i;
  logic [BW-1:0]               master_r_rdata_i;

  int checks = 0;
  int errors = 0;

  dm_sba_arbiter #(
    .BusWidth      (BW),
    .NumReq        (NR),
    .TimeoutCycles (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .dmactive_i       (dmactive_i),
    .req_i            (req_i),
    .add_i            (add_i),
    .we_i             (we_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_err_o          (r_err_o),
    .r_rdata_o        (r_rdata_o),
    .master_req_o     (master_req_o),
    .master_add_o     (master_add_o),
    .master_we_o      (master_we_o),
    .master_wdata_o   (master_wdata_o),
    .master_be_o      (master_be_o),
    .master_gnt_i     (master_gnt_i),
    .master_r_valid_i (master_r_valid_i),
    .master_r_rdata_i (master_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp;
    rst_ni           = 1'b0;
    dmactive_i       = 1'b0;
    req_i            = '0;
    add_i            = '0;
    we_i             = '0;
    wdata_i          = '0;
    be_i             = '0;
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;
    #1;
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_rvalid", 64'(r_valid_o), 0);
    chk("rst_rerr", 64'(r_err_o), 0);
    chk("rst_mreq", 64'(master_req_o), 0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni     = 1'b1;
    dmactive_i = 1'b1;

    // Round robin: both requesters hold req, immediate grant, 1-cycle response
    add_i[0]     = 32'hA0;
    add_i[1]     = 32'hB0;
    req_i        = 2'b11;
    master_gnt_i = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_idle_mreq", 64'(master_req_o), 0);
      chk("rr_idle_gnt", 64'(gnt_o), 0);
      tick();
      chk("rr_gnt", 64'(gnt_o), 64'(exp));
      chk("rr_add", 64'(master_add_o), (exp == 2'b01) ? 64'hA0 : 64'hB0);
      tick();
      master_r_valid_i = 1'b1;
      master_r_rdata_i = BW'(t + 7);
      #1;
      chk("rr_rvalid", 64'(r_valid_o), 64'(exp));
      chk("rr_rdata", 64'(r_rdata_o), 64'(t + 7));
      chk("rr_wait_gnt", 64'(gnt_o), 0);
      tick();
      master_r_valid_i = 1'b0;
      #1;
    end
    req_i        = '0;
    master_gnt_i = 1'b0;
    #1;

    // Single read from requester 0
    tick();
    add_i[0] = 32'h1000;
    we_i     = '0;
    req_i    = 2'b01;
    #1;
    chk("rd_idle_mreq", 64'(master_req_o), 0);
    tick();
    chk("rd_mreq", 64'(master_req_o), 1);
    chk("rd_add", 64'(master_add_o), 64'h1000);
    chk("rd_nognt", 64'(gnt_o), 0);
    tick();
    master_gnt_i = 1'b1;
    #1;
    chk("rd_gnt", 64'(gnt_o), 64'b01);
    tick();
    master_gnt_i = 1'b0;
    #1;
    chk("rd_wait_mreq", 64'(master_req_o), 0);
    chk("rd_wait_rvalid", 64'(r_valid_o), 0);
    tick();
    tick();
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'hDEADBEEF;
    #1;
    chk("rd_rvalid", 64'(r_valid_o), 64'b01);
    chk("rd_rdata", 64'(r_rdata_o), 64'hDEADBEEF);
    req_i = '0;
    tick();
    master_r_valid_i = 1'b0;
    #1;
    chk("rd_done_mreq", 64'(master_req_o), 0);

    // Write mux from requester 1 (round-robin pointer now at 1)
    req_i      = 2'b10;
    we_i       = 2'b10;
    add_i[1]   = 32'h2004;
    wdata_i[1] = 32'h55AA;
    be_i[1]    = 4'h3;
    #1;
    chk("wr_idle_mreq", 64'(master_req_o), 0);
    tick();
    chk("wr_we", 64'(master_we_o), 1);
    chk("wr_add", 64'(master_add_o), 64'h2004);
    chk("wr_wdata", 64'(master_wdata_o), 64'h55AA);
    chk("wr_be", 64'(master_be_o), 64'h3);
    chk("wr_nognt", 64'(gnt_o), 0);
    tick();
    chk("wr_add_stable", 64'(master_add_o), 64'h2004);
    chk("wr_we_stable", 64'(master_we_o), 1);
    master_gnt_i = 1'b1;
    #1;
    chk("wr_gnt", 64'(gnt_o), 64'b10);
    tick();
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b1;
    #1;
    chk("wr_rvalid", 64'(r_valid_o), 64'b10);
    req_i = '0;
    we_i  = '0;
    tick();
    master_r_valid_i = 1'b0;
    #1;

    // Requester 0 aborts before grant
    req_i = 2'b01;
    #1;
    tick();
    chk("ab_mreq", 64'(master_req_o), 1);
    req_i = '0;
    #1;
    chk("ab_drop_mreq", 64'(master_req_o), 0);
    tick();
    chk("ab_idle_mreq", 64'(master_req_o), 0);
    tick();
    chk("ab_idle2_mreq", 64'(master_req_o), 0);
    chk("ab_idle2_gnt", 64'(gnt_o), 0);

    // Soft clear while waiting for the response
    req_i = 2'b01;
    #1;
    tick();
    master_gnt_i = 1'b1;
    #1;
    chk("sc_gnt", 64'(gnt_o), 64'b01);
    tick();
    master_gnt_i = 1'b0;
    dmactive_i   = 1'b0;
    #1;
    chk("sc_wait_rvalid", 64'(r_valid_o), 0);
    tick();
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h1234;
    #1;
    chk("sc_rvalid", 64'(r_valid_o), 0);
    chk("sc_rdata", 64'(r_rdata_o), 64'h1234);
    tick();
    master_r_valid_i = 1'b0;
    #1;
    chk("sc_idle_mreq", 64'(master_req_o), 0);
    tick();
    chk("sc_inactive_mreq", 64'(master_req_o), 0);
    dmactive_i = 1'b1;
    #1;
    tick();
    chk("sc_rearb_mreq", 64'(master_req_o), 1);

    // Asynchronous reset in the middle of Wait
    master_gnt_i = 1'b1;
    #1;
    chk("rs_gnt", 64'(gnt_o), 64'b01);
    tick();
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b1;
    #1;
    chk("rs_rvalid", 64'(r_valid_o), 64'b01);
    rst_ni = 1'b0;
    #1;
    chk("rs_async_rvalid", 64'(r_valid_o), 0);
    chk("rs_async_mreq", 64'(master_req_o), 0);
    chk("rs_async_gnt", 64'(gnt_o), 0);
    master_r_valid_i = 1'b0;
    tick();
    rst_ni       = 1'b1;
    req_i        = 2'b11;
    master_gnt_i = 1'b1;
    #1;
    chk("rs_idle_mreq", 64'(master_req_o), 0);
    tick();
    chk("rs_ptr_gnt", 64'(gnt_o), 64'b01);
    tick();
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b1;
    req_i            = '0;
    #1;
    tick();
    master_r_valid_i = 1'b0;
    #1;

`ifdef DM_SBA_ARB_TIMEOUT_EN
    // Bus never answers: error pulse after 16 Wait cycles, then Drain
    req_i = 2'b01;
    #1;
    tick();
    master_gnt_i = 1'b1;
    #1;
    tick();
    master_gnt_i     = 1'b0;
    master_r_rdata_i = 32'hFFFF;
    #1;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_rvalid", 64'(r_valid_o), 0);
      tick();
    end
    chk("to_rvalid", 64'(r_valid_o), 64'b01);
    chk("to_rerr", 64'(r_err_o), 64'b01);
    chk("to_rdata", 64'(r_rdata_o), 0);
    req_i        = 2'b11;
    master_gnt_i = 1'b1;
    #1;
    tick();
    chk("dr_gnt", 64'(gnt_o), 0);
    chk("dr_mreq", 64'(master_req_o), 0);
    tick();
    chk("dr_gnt2", 64'(gnt_o), 0);
    master_r_valid_i = 1'b1;
    #1;
    chk("dr_rvalid", 64'(r_valid_o), 0);
    tick();
    master_r_valid_i = 1'b0;
    #1;
    tick();
    chk("dr_next_gnt", 64'(gnt_o), 64'b10);
    req_i        = '0;
    master_gnt_i = 1'b0;
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
